// File: rtl/mips_pkg.sv
// Shared myMIPS definitions: opcodes, ALU commands and the ID/EX control bundle.
package mips_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_ANDI  = 4'h6;
    localparam logic [3:0] OP_ORI   = 4'h7;
    localparam logic [3:0] OP_J     = 4'h8;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SHL = 3'b010;
    localparam logic [2:0] ALU_SGT = 3'b011;
    localparam logic [2:0] ALU_SHR = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    typedef struct packed {
        logic [2:0]        cmd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] wr_addr;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic              reg_we;
        logic              mem_rd;
        logic              mem_wr;
        logic              branch;
        logic              jump;
        logic              illegal;
        logic              uses_rs;
        logic              uses_rt;
    } idex_ctrl_t;

    function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
        return {{(DATA_W-6){v[5]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] zext6(input logic [5:0] v);
        return {{(DATA_W-6){1'b0}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] zext12(input logic [11:0] v);
        return {{(DATA_W-12){1'b0}}, v};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of one 16-bit myMIPS word into the ID/EX control bundle.
module instr_decode
    import mips_pkg::*;
(
    input  logic [15:0] instr_i,
    output idex_ctrl_t  ctrl_o
);

    logic [3:0] op;

    always_comb begin
        op             = instr_i[15:12];
        ctrl_o         = '0;
        ctrl_o.rs      = instr_i[11:9];
        ctrl_o.rt      = instr_i[8:6];
        unique case (op)
            OP_RTYPE: begin
                ctrl_o.cmd     = instr_i[2:0];
                ctrl_o.wr_addr = instr_i[5:3];
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.uses_rs = 1'b1;
                ctrl_o.uses_rt = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                ctrl_o.cmd     = ALU_ADD;
                ctrl_o.imm     = sext6(instr_i[5:0]);
                ctrl_o.use_imm = 1'b1;
                ctrl_o.wr_addr = instr_i[8:6];
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.mem_rd  = (op == OP_LW);
                ctrl_o.uses_rs = 1'b1;
            end
            OP_SW: begin
                ctrl_o.cmd     = ALU_ADD;
                ctrl_o.imm     = sext6(instr_i[5:0]);
                ctrl_o.use_imm = 1'b1;
                ctrl_o.mem_wr  = 1'b1;
                ctrl_o.uses_rs = 1'b1;
                ctrl_o.uses_rt = 1'b1;
            end
            OP_BEQ: begin
                // Offset goes to the branch adder; the ALU compares rs and rt.
                ctrl_o.cmd     = ALU_EQ;
                ctrl_o.imm     = sext6(instr_i[5:0]);
                ctrl_o.branch  = 1'b1;
                ctrl_o.uses_rs = 1'b1;
                ctrl_o.uses_rt = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                ctrl_o.cmd     = (op == OP_ANDI) ? ALU_AND : ALU_OR;
                ctrl_o.imm     = zext6(instr_i[5:0]);
                ctrl_o.use_imm = 1'b1;
                ctrl_o.wr_addr = instr_i[8:6];
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.uses_rs = 1'b1;
            end
            OP_J: begin
                ctrl_o.cmd  = ALU_ADD;
                ctrl_o.imm  = zext12(instr_i[11:0]);
                ctrl_o.jump = 1'b1;
            end
            default: begin
                ctrl_o.illegal = 1'b1;
            end
        endcase
        // r0 is hardwired to zero, so writing it is pointless and must not stall.
        if (ctrl_o.wr_addr == '0) begin
            ctrl_o.reg_we = 1'b0;
        end
    end

endmodule

// File: rtl/id_issue.sv
// myMIPS decode-and-issue stage: ID/EX register, handshake, load-use bubble, flush.
// Optional sticky illegal-opcode flag under DECODE_ILLEGAL_TRAP_EN.
module id_issue
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = 16,
    parameter int unsigned RAW  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [15:0]     in_instr,
    output logic            in_ready,
    input  logic            flush,
    input  logic            out_ready,
    output logic            ex_valid,
    output logic [2:0]      ex_cmd,
    output logic [RAW-1:0]  ex_rs,
    output logic [RAW-1:0]  ex_rt,
    output logic [RAW-1:0]  ex_wr_addr,
    output logic [XLEN-1:0] ex_imm,
    output logic            ex_use_imm,
    output logic            ex_reg_we,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic [RAW-1:0]  rf_ra1,
    output logic [RAW-1:0]  rf_ra2
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic            illegal
`endif
);

    idex_ctrl_t dec;
    idex_ctrl_t ctrl_d, ctrl_q;
    logic       valid_d, valid_q;
    logic       hazard;
    logic       accept;

    instr_decode u_decode (
        .instr_i (in_instr),
        .ctrl_o  (dec)
    );

    assign rf_ra1 = in_instr[11:9];
    assign rf_ra2 = in_instr[8:6];

    assign hazard = valid_q & ctrl_q.mem_rd & ctrl_q.reg_we &
                    ((dec.uses_rs & (dec.rs == ctrl_q.wr_addr)) |
                     (dec.uses_rt & (dec.rt == ctrl_q.wr_addr)));

    assign in_ready = (~valid_q | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = dec;
        end else if (valid_q & ~out_ready) begin
            valid_d = valid_q;
        end else begin
            // Drain, or the load-use bubble while the consumer waits upstream.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_cmd     = ctrl_q.cmd;
    assign ex_rs      = ctrl_q.rs;
    assign ex_rt      = ctrl_q.rt;
    assign ex_wr_addr = ctrl_q.wr_addr;
    assign ex_imm     = ctrl_q.imm;
    assign ex_use_imm = ctrl_q.use_imm;
    assign ex_reg_we  = ctrl_q.reg_we;
    assign ex_mem_rd  = ctrl_q.mem_rd;
    assign ex_mem_wr  = ctrl_q.mem_wr;
    assign ex_branch  = ctrl_q.branch;
    assign ex_jump    = ctrl_q.jump;

    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl_q.uses_rs, ctrl_q.uses_rt, ctrl_q.illegal};

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_d, illegal_q;

    assign illegal_d = illegal_q | (accept & dec.illegal);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = dec.illegal;
`endif

endmodule

// File: tb/tb_id_issue.sv
// Self-checking bench for id_issue: directed scenarios plus randomized traffic
// against a behavioural model. Honours DECODE_ILLEGAL_TRAP_EN.
module tb_id_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = 16'h0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic        ex_valid;
    logic [2:0]  ex_cmd;
    logic [2:0]  ex_rs, ex_rt, ex_wr_addr;
    logic [15:0] ex_imm;
    logic        ex_use_imm, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump;
    logic [2:0]  rf_ra1, rf_ra2;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_ready  (out_ready),
        .ex_valid   (ex_valid),
        .ex_cmd     (ex_cmd),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_wr_addr (ex_wr_addr),
        .ex_imm     (ex_imm),
        .ex_use_imm (ex_use_imm),
        .ex_reg_we  (ex_reg_we),
        .ex_mem_rd  (ex_mem_rd),
        .ex_mem_wr  (ex_mem_wr),
        .ex_branch  (ex_branch),
        .ex_jump    (ex_jump),
        .rf_ra1     (rf_ra1),
        .rf_ra2     (rf_ra2)
`ifdef DECODE_ILLEGAL_TRAP_EN
        ,
        .illegal    (illegal)
`endif
    );

    // Expected meaning of one instruction word, straight from the ISA table.
    typedef struct {
        logic [2:0]  cmd;
        logic [2:0]  rs, rt, wr;
        logic [15:0] imm;
        logic        use_imm, we, memrd, memwr, br, jmp, ill;
        logic        has_wr, has_imm, chk_use, use_rs, use_rt;
    } ref_t;

    ref_t m_rec;
    logic m_valid = 1'b0;
    logic m_ill = 1'b0;
    logic rdy_seen;

    function automatic ref_t ref_decode(input logic [15:0] w);
        ref_t r;
        int   v, op, rs, rt, rd, fn, i6, s6;
        v  = int'(w);
        op = v / 4096;
        rs = (v / 512) % 8;
        rt = (v / 64) % 8;
        rd = (v / 8) % 8;
        fn = v % 8;
        i6 = v % 64;
        s6 = (i6 >= 32) ? i6 - 64 : i6;
        r.cmd = 3'd0; r.rs = 3'(rs); r.rt = 3'(rt); r.wr = 3'd0; r.imm = 16'd0;
        r.use_imm = 0; r.we = 0; r.memrd = 0; r.memwr = 0; r.br = 0; r.jmp = 0;
        r.ill = 0; r.has_wr = 0; r.has_imm = 0; r.chk_use = 1; r.use_rs = 0; r.use_rt = 0;
        case (op)
            0: begin r.cmd = 3'(fn); r.has_wr = 1; r.wr = 3'(rd); r.use_rs = 1; r.use_rt = 1; end
            1, 2: begin
                r.imm = 16'(s6); r.has_imm = 1; r.use_imm = 1;
                r.has_wr = 1; r.wr = 3'(rt); r.use_rs = 1; r.memrd = (op == 2);
            end
            3: begin
                r.imm = 16'(s6); r.has_imm = 1; r.use_imm = 1; r.memwr = 1;
                r.use_rs = 1; r.use_rt = 1;
            end
            4: begin
                r.cmd = 3'd7; r.imm = 16'(s6); r.has_imm = 1; r.br = 1;
                r.use_rs = 1; r.use_rt = 1;
            end
            6, 7: begin
                r.cmd = (op == 6) ? 3'd5 : 3'd6; r.imm = 16'(i6); r.has_imm = 1;
                r.use_imm = 1; r.has_wr = 1; r.wr = 3'(rt); r.use_rs = 1;
            end
            8: begin r.imm = 16'(v % 4096); r.has_imm = 1; r.jmp = 1; r.chk_use = 0; end
            default: r.ill = 1;
        endcase
        r.we = r.has_wr && (r.wr != 3'd0);
        return r;
    endfunction

    // One clock: drive at negedge, check in_ready/rf reads, advance model, check EX.
    task automatic step(input logic rst, input logic v, input logic [15:0] w,
                        input logic ordy, input logic fl);
        ref_t d;
        logic hz, exp_rdy;
        @(negedge clk);
        rst_n = rst; in_valid = v; in_instr = w; out_ready = ordy; flush = fl;
        #1;
        d  = ref_decode(w);
        hz = m_valid && m_rec.memrd && m_rec.we &&
             ((d.use_rs && d.rs == m_rec.wr) || (d.use_rt && d.rt == m_rec.wr));
        exp_rdy  = (!m_valid || ordy) && !hz && !fl;
        rdy_seen = in_ready;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b (instr %h)", in_ready, exp_rdy, w);
        end
        checks++;
        if ({rf_ra1, rf_ra2} !== {d.rs, d.rt}) begin
            errors++;
            $display("FAIL rf_ra: got %0d/%0d expected %0d/%0d", rf_ra1, rf_ra2, d.rs, d.rt);
        end
        @(posedge clk);
        if (!rst) begin
            m_valid = 0; m_ill = 0;
        end else if (fl) begin
            m_valid = 0;
        end else if (v && exp_rdy) begin
            m_valid = 1; m_rec = d;
            if (d.ill) m_ill = 1;
        end else if (!(m_valid && !ordy)) begin
            m_valid = 0;
        end
        #1;
        checks++;
        if (ex_valid !== m_valid) begin
            errors++;
            $display("FAIL ex_valid: got %b expected %b", ex_valid, m_valid);
        end
        if (m_valid) begin
            checks++;
            if ({ex_cmd, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump} !==
                {m_rec.cmd, m_rec.we, m_rec.memrd, m_rec.memwr, m_rec.br, m_rec.jmp}) begin
                errors++;
                $display("FAIL ex_ctrl: got cmd %b we%b rd%b wr%b br%b j%b expected cmd %b we%b rd%b wr%b br%b j%b",
                         ex_cmd, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump,
                         m_rec.cmd, m_rec.we, m_rec.memrd, m_rec.memwr, m_rec.br, m_rec.jmp);
            end
            if (!m_rec.ill) begin
                checks++;
                if ({ex_rs, ex_rt} !== {m_rec.rs, m_rec.rt}) begin
                    errors++;
                    $display("FAIL ex_rs_rt: got %0d/%0d expected %0d/%0d",
                             ex_rs, ex_rt, m_rec.rs, m_rec.rt);
                end
            end
            if (m_rec.has_wr) begin
                checks++;
                if (ex_wr_addr !== m_rec.wr) begin
                    errors++;
                    $display("FAIL ex_wr_addr: got %0d expected %0d", ex_wr_addr, m_rec.wr);
                end
            end
            if (m_rec.has_imm) begin
                checks++;
                if (ex_imm !== m_rec.imm) begin
                    errors++;
                    $display("FAIL ex_imm: got %h expected %h", ex_imm, m_rec.imm);
                end
            end
            if (m_rec.chk_use) begin
                checks++;
                if (ex_use_imm !== m_rec.use_imm) begin
                    errors++;
                    $display("FAIL ex_use_imm: got %b expected %b", ex_use_imm, m_rec.use_imm);
                end
            end
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== m_ill) begin
            errors++;
            $display("FAIL illegal: got %b expected %b", illegal, m_ill);
        end
`endif
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        checks++;
        if ({ex_valid, ex_cmd, ex_rs, ex_rt, ex_wr_addr, ex_imm, ex_use_imm, ex_reg_we,
             ex_mem_rd, ex_mem_wr, ex_branch, ex_jump} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero ex_* (imm %h cmd %b) expected all 0",
                     ex_imm, ex_cmd);
        end
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (rdy_seen !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", rdy_seen);
        end
    endtask

    task automatic test_rtype();
        step(1'b1, 1'b1, 16'h0A6D, 1'b1, 1'b0);
        checks++;
        if ({ex_valid, ex_cmd, ex_wr_addr, ex_reg_we} !== {1'b1, 3'b101, 3'd5, 1'b1}) begin
            errors++;
            $display("FAIL rtype: got v%b cmd %b wr %0d we %b expected v1 cmd 101 wr 5 we 1",
                     ex_valid, ex_cmd, ex_wr_addr, ex_reg_we);
        end
    endtask

    task automatic test_imm();
        step(1'b1, 1'b1, 16'h1A7E, 1'b1, 1'b0);
        checks++;
        if ({ex_imm, ex_use_imm} !== {16'hFFFE, 1'b1}) begin
            errors++;
            $display("FAIL addi_imm: got %h/%b expected fffe/1", ex_imm, ex_use_imm);
        end
        step(1'b1, 1'b1, 16'h7A7E, 1'b1, 1'b0);
        checks++;
        if (ex_imm !== 16'h003E) begin
            errors++;
            $display("FAIL ori_imm: got %h expected 003e", ex_imm);
        end
    endtask

    task automatic test_hazard();
        step(1'b1, 1'b1, 16'h2240, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h0288, 1'b1, 1'b0);
        checks++;
        if ({rdy_seen, ex_valid} !== 2'b00) begin
            errors++;
            $display("FAIL hazard_bubble: got rdy %b valid %b expected 0 0", rdy_seen, ex_valid);
        end
        step(1'b1, 1'b1, 16'h0288, 1'b1, 1'b0);
        checks++;
        if ({rdy_seen, ex_valid, ex_rs, ex_rt} !== {2'b11, 3'd1, 3'd2}) begin
            errors++;
            $display("FAIL hazard_issue: got rdy %b valid %b rs %0d rt %0d expected 1 1 1 2",
                     rdy_seen, ex_valid, ex_rs, ex_rt);
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b1, 16'h1A7E, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 16'h7A7E, 1'b0, 1'b0);
            checks++;
            if ({rdy_seen, ex_valid, ex_cmd, ex_imm} !== {2'b01, 3'b000, 16'hFFFE}) begin
                errors++;
                $display("FAIL stall_hold: got rdy %b valid %b cmd %b imm %h expected 0 1 000 fffe",
                         rdy_seen, ex_valid, ex_cmd, ex_imm);
            end
        end
        step(1'b1, 1'b1, 16'h7A7E, 1'b1, 1'b0);
        checks++;
        if ({rdy_seen, ex_valid, ex_cmd, ex_imm} !== {2'b11, 3'b110, 16'h003E}) begin
            errors++;
            $display("FAIL stall_release: got rdy %b valid %b cmd %b imm %h expected 1 1 110 003e",
                     rdy_seen, ex_valid, ex_cmd, ex_imm);
        end
    endtask

    task automatic test_flush();
        step(1'b1, 1'b1, 16'h2240, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h0288, 1'b1, 1'b1);
        checks++;
        if ({rdy_seen, ex_valid} !== 2'b00) begin
            errors++;
            $display("FAIL flush: got rdy %b valid %b expected 0 0", rdy_seen, ex_valid);
        end
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_accept: got valid %b expected 0", ex_valid);
        end
    endtask

    task automatic test_illegal();
        step(1'b1, 1'b1, 16'hF000, 1'b1, 1'b0);
        checks++;
        if ({ex_valid, ex_cmd, ex_use_imm, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump}
            !== {1'b1, 3'b000, 6'b0}) begin
            errors++;
            $display("FAIL illegal_nop: got valid %b cmd %b flags %b%b%b%b%b%b expected 1 000 000000",
                     ex_valid, ex_cmd, ex_use_imm, ex_reg_we, ex_mem_rd, ex_mem_wr,
                     ex_branch, ex_jump);
        end
        step(1'b1, 1'b1, 16'h1A7E, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky: got %b expected 1", illegal);
        end
`endif
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_reset: got %b expected 0", illegal);
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        step(1'b1, 1'b1, 16'h1A7E, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h1A7E, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h1A7E, 1'b0, 1'b0);
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: got valid %b expected 0", ex_valid);
        end
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] w;
        logic [3:0]  legal [8];
        legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8};
        for (int i = 0; i < 2000; i++) begin
            w = 16'($urandom);
            if ($urandom_range(9) != 0) w[15:12] = legal[$urandom_range(7)];
            if ($urandom_range(1) == 0) begin
                // Narrow the register range so load-use conflicts happen often.
                w[11] = 1'b0;
                w[8]  = 1'b0;
            end
            step(($urandom_range(199) != 0), ($urandom_range(3) != 0), w,
                 ($urandom_range(3) != 0), ($urandom_range(15) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_imm();
        test_hazard();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_issue.md
# id_issue

Decode-and-issue stage for the 16-bit myMIPS pipeline, and the producer of the ALU command interface. It accepts one 16-bit instruction per cycle over a valid/ready handshake. Each instruction is decoded into the 3-bit ALU command, a sign- or zero-extended immediate, operand select and control flags, which are registered into the ID/EX pipeline register. It also detects load-use hazards and inserts one bubble, and it honours a flush from branch/jump resolution.

## Interface
Parameters:
- `XLEN`, 16: datapath and immediate width.
- `RAW`, 3: register address width.

Ports:
- `clk` input 1: single clock. Everything is on the rising edge.
- `rst_n` input 1: reset. Synchronous and active-low.
- `in_valid` input 1: the fetch stage presents an instruction.
- `in_instr` input 16: instruction word.
- `in_ready` output 1: the stage accepts `in_instr` this cycle.
- `flush` input 1: kill the instruction in the stage and refuse input this cycle.
- `out_ready` input 1: the EX stage can take the registered instruction.
- `ex_valid` output 1: the pipeline register holds a live instruction.
- `ex_cmd` output 3: ALU command. 000 add, 001 sub, 010 shl, 011 signed gt, 100 shr, 101 and, 110 or, 111 eq.
- `ex_rs`, `ex_rt` output RAW: source register addresses.
- `ex_wr_addr` output RAW: destination register address.
- `ex_imm` output XLEN: extended immediate.
- `ex_use_imm` output 1: OP2 takes `ex_imm` instead of rt.
- `ex_reg_we`, `ex_mem_rd`, `ex_mem_wr`, `ex_branch`, `ex_jump` output 1 each: control flags.
- `rf_ra1`, `rf_ra2` output RAW: register-file read addresses. These are combinational from `in_instr` and equal bits [11:9] and [8:6].
- `illegal` output 1: sticky illegal-opcode flag. Present only when `DECODE_ILLEGAL_TRAP_EN` is defined.

## Operation
Instruction field layout:
- op = [15:12]
- rs = [11:9]
- rt = [8:6]
- rd = [5:3]
- funct = [2:0]
- imm6 = [5:0]
- imm12 = [11:0]

Decode per opcode:
- 0000 R-type: cmd = funct. Destination is rd. Uses rs and rt.
- 0001 addi: cmd 000. imm6 sign-extended. Destination is rt. Uses rs.
- 0010 lw: cmd 000. imm6 sign-extended. Destination is rt. Sets `ex_mem_rd`. Uses rs.
- 0011 sw: cmd 000. imm6 sign-extended. No write. Sets `ex_mem_wr`. Uses rs and rt.
- 0100 beq: cmd 111. imm6 sign-extended, but `ex_use_imm` = 0. Sets `ex_branch`. Uses rs and rt.
- 0110 andi: cmd 101. imm6 zero-extended. Destination is rt. Uses rs.
- 0111 ori: cmd 110. imm6 zero-extended. Destination is rt. Uses rs.
- 1000 j: imm12 zero-extended. Sets `ex_jump`. cmd 000. No register use.
- Any other opcode is illegal. It is issued as a NOP: all flags 0, cmd 000.

Decode rules:
- `ex_reg_we` is forced to 0 whenever the destination is register 0.
- Load-use hazard: `ex_valid`, `ex_mem_rd` and `ex_reg_we` are all 1, and `ex_wr_addr` equals a register the incoming instruction uses.
- Handshake: `in_ready` = (!`ex_valid` | `out_ready`) & !hazard & !`flush`.

Stage update on each clock:
- Accept (`in_valid` & `in_ready`): load the decoded fields and set `ex_valid` = 1.
- Hazard with `ex_valid` & `out_ready`: load a bubble (`ex_valid` = 0). The instruction is held upstream and is accepted the next cycle.
- `ex_valid` & !`out_ready`: hold all registers unchanged.
- Otherwise, when the current instruction drains: `ex_valid` = 0.
- `flush`: `ex_valid` = 0 next cycle. Flush overrides stall, hazard and accept.

## Timing
- Latency is 1 cycle from accept to `ex_valid`.
- Sustained throughput is 1 instruction per cycle.
- A load-use hazard costs exactly one bubble cycle.
- Reset value of every `ex_*` output and of `illegal` is 0.
- `in_ready` is 1 after reset, because the stage is empty.
- Reset asserted mid-stall discards the held instruction.
- `rf_ra1`/`rf_ra2` have zero latency, so the register file is read in the same cycle as decode.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined: the `illegal` port exists. It sets on acceptance of an illegal opcode and clears only on reset. The NOP is still issued.
- `DECODE_ILLEGAL_TRAP_EN` undefined: no `illegal` port, and illegal opcodes become silent NOPs.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_ANDI, OP_ORI, OP_J);
  - ALU command constants (ALU_ADD … ALU_EQ);
  - the ID/EX control-bundle typedef.
- Sub-module `instr_decode`: purely combinational decode of one word into the control bundle, including the uses-rs/uses-rt flags.
- `id_issue` owns the pipeline register, the handshake, hazard detection and flush.

## Test plan
- Reset, then `in_instr`=0x0A6D (R-type: rs=5, rt=1, rd=5, funct=5) with `out_ready`=1 → next cycle `ex_valid`=1, `ex_cmd`=101, `ex_wr_addr`=5, `ex_reg_we`=1.
- addi 0x1A7E (rs=5, rt=1, imm=−2) → `ex_imm`=0xFFFE, `ex_use_imm`=1. Then ori 0x7A7E → `ex_imm`=0x003E.
- lw 0x2240 (rs=1, rt=1, imm 0), then R-type 0x0288 (rs=1, rt=2) → `in_ready`=0 for one cycle, then a bubble (`ex_valid`=0), then the R-type issues.
- `out_ready`=0 for 3 cycles with the stage full → `ex_*` stable and `in_ready`=0. Release → the stage drains, and the next word is accepted that cycle.
- `flush` asserted together with `in_valid` and a hazard → next cycle `ex_valid`=0 and the instruction is not accepted.
- Opcode 0xF000 → NOP issued. With the macro: `illegal` goes to 1 and stays 1 until `rst_n`=0.
